// File: rtl/mouse_pos_bcd_if.sv
// ---------------------------------------------------------------------------
// mouse_pos_bcd_if
//   Bundle between the PS/2 mouse position logic and the BCD converter that
//   feeds the seven-segment decoders.
//
//   master : drives x_pos, y_pos, refresh; receives digits and status.
//   slave  : the converter; receives the position, drives digits/status.
//
//   x_pos, y_pos     WIDTH  binned position
//   refresh          1      force a conversion with unchanged inputs
//   x/y_ones/tens/hund 4    BCD digits per axis
//   x_ovf, y_ovf     1      captured value exceeded the saturation limit
//   valid            1      one-cycle strobe when new digits are registered
//   busy             1      conversion in progress
// ---------------------------------------------------------------------------
interface mouse_pos_bcd_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] x_pos;
  logic [WIDTH-1:0] y_pos;
  logic             refresh;
  logic [3:0]       x_ones, x_tens, x_hund;
  logic [3:0]       y_ones, y_tens, y_hund;
  logic             x_ovf, y_ovf;
  logic             valid;
  logic             busy;

  modport master (
    output x_pos, y_pos, refresh,
    input  x_ones, x_tens, x_hund, y_ones, y_tens, y_hund,
    input  x_ovf, y_ovf, valid, busy
  );

  modport slave (
    input  x_pos, y_pos, refresh,
    output x_ones, x_tens, x_hund, y_ones, y_tens, y_hund,
    output x_ovf, y_ovf, valid, busy
  );
endinterface

// File: rtl/mouse_pos_bcd.sv
// ---------------------------------------------------------------------------
// mouse_pos_bcd
//   Sequential binary-to-BCD converter for the mouse x/y position. When
//   either coordinate changes (or refresh is pulsed, or after reset) both
//   axes are converted in parallel with shift-and-add-3, one bit per clock,
//   and three decimal digits per axis are registered with a valid strobe.
//
//   Ports:
//     clk  system clock
//     clr  asynchronous active-low reset
//     bus  mouse_pos_bcd_if.slave (position in, digits/status out)
//
//   Timing: start edge E0 in IDLE, shifts on E1..E(WIDTH), outputs and valid
//   on E(WIDTH+1). Minimum conversion period is WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module mouse_pos_bcd #(
  parameter int WIDTH = 11,
  parameter int SAT   = 999
) (
  input  logic                clk,
  input  logic                clr,
  mouse_pos_bcd_if.slave      bus
);

  localparam int               SRW   = 12 + WIDTH;
  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SAT_W = WIDTH'(SAT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [SRW-1:0]   sr_x, sr_y;
  logic [WIDTH-1:0] raw_x, raw_y;
  logic [WIDTH-1:0] last_x, last_y;
  logic             ovf_x, ovf_y;
  logic             pending;
  logic [CNT_W-1:0] cnt;

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v);
    return (v > SAT_W) ? SAT_W : v;
  endfunction

  // One double-dabble iteration: correct every BCD nibble that would
  // overflow past 9 when doubled, then shift the whole register left.
  function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] sr);
    logic [SRW-1:0] t;
    logic [3:0]     nib;
    // NOTE: blocking '=' is right here -- t and nib are function-local
    // temporaries evaluated in order, not clocked state.
    t = sr;
    for (int d = 0; d < 3; d++) begin
      nib = t[WIDTH + 4*d +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;  // 4-bit add, no carry out
      t[WIDTH + 4*d +: 4] = nib;
    end
    return {t[SRW-2:0], 1'b0};
  endfunction

  logic start;
  assign start = (bus.x_pos != last_x) || (bus.y_pos != last_y) ||
                 bus.refresh || pending;

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      sr_x       <= '0;
      sr_y       <= '0;
      raw_x      <= '0;
      raw_y      <= '0;
      last_x     <= '0;
      last_y     <= '0;
      ovf_x      <= 1'b0;
      ovf_y      <= 1'b0;
      pending    <= 1'b1;  // guarantees exactly one conversion after reset
      cnt        <= '0;
      bus.x_ones <= '0;
      bus.x_tens <= '0;
      bus.x_hund <= '0;
      bus.y_ones <= '0;
      bus.y_tens <= '0;
      bus.y_hund <= '0;
      bus.x_ovf  <= 1'b0;
      bus.y_ovf  <= 1'b0;
      bus.valid  <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr_x     <= {12'd0, saturate(bus.x_pos)};
            sr_y     <= {12'd0, saturate(bus.y_pos)};
            raw_x    <= bus.x_pos;
            raw_y    <= bus.y_pos;
            ovf_x    <= (bus.x_pos > SAT_W);
            ovf_y    <= (bus.y_pos > SAT_W);
            pending  <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr_x <= dabble_step(sr_x);
          sr_y <= dabble_step(sr_y);
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          bus.x_ones <= sr_x[WIDTH +: 4];
          bus.x_tens <= sr_x[WIDTH + 4 +: 4];
          bus.x_hund <= sr_x[WIDTH + 8 +: 4];
          bus.y_ones <= sr_y[WIDTH +: 4];
          bus.y_tens <= sr_y[WIDTH + 4 +: 4];
          bus.y_hund <= sr_y[WIDTH + 8 +: 4];
          bus.x_ovf  <= ovf_x;
          bus.y_ovf  <= ovf_y;
          // Raw (unsaturated) values, so 1500 -> 1600 still retriggers.
          last_x     <= raw_x;
          last_y     <= raw_y;
          bus.valid  <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_pos_bcd.sv
// ---------------------------------------------------------------------------
// tb_mouse_pos_bcd
//   Self-checking bench for mouse_pos_bcd. Expected digit records are pushed
//   to a scoreboard queue when a conversion is started; a monitor pops and
//   compares them whenever valid is seen.
// ---------------------------------------------------------------------------
module tb_mouse_pos_bcd;

  localparam int WIDTH = 11;

  typedef struct {
    int xh, xt, xo, yh, yt, yo;
    int xv, yv;
  } exp_t;

  typedef struct {
    int   x, y;
    exp_t e;
  } vec_t;

  logic clk;
  logic clr;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  mouse_pos_bcd_if #(.WIDTH(WIDTH)) bus ();

  mouse_pos_bcd #(.WIDTH(WIDTH), .SAT(999)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk_exp(int xh, int xt, int xo, int yh, int yt,
                                  int yo, int xv, int yv);
    exp_t e;
    e.xh = xh; e.xt = xt; e.xo = xo;
    e.yh = yh; e.yt = yt; e.yo = yo;
    e.xv = xv; e.yv = yv;
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (clr && bus.valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_hund", int'(bus.x_hund), e.xh);
        check("x_tens", int'(bus.x_tens), e.xt);
        check("x_ones", int'(bus.x_ones), e.xo);
        check("y_hund", int'(bus.y_hund), e.yh);
        check("y_tens", int'(bus.y_tens), e.yt);
        check("y_ones", int'(bus.y_ones), e.yo);
        check("x_ovf",  int'(bus.x_ovf),  e.xv);
        check("y_ovf",  int'(bus.y_ovf),  e.yv);
        check("busy_low_with_valid", int'(bus.busy), 0);
      end
    end
  end

  // Counts falling edges until valid is seen; a blown budget is a failure.
  task automatic wait_valid(input string name, input int req_lat);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.valid) break;
    end
    if (!bus.valid) check({name, "_timeout"}, 0, 1);
    else            check({name, "_latency"}, n, req_lat);
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
  endtask

  vec_t vecs[7];
  int   nv;

  initial begin
    vecs[0] = '{x: 639,  y: 479,  e: mk_exp(6, 3, 9, 4, 7, 9, 0, 0)};
    vecs[1] = '{x: 1500, y: 1000, e: mk_exp(9, 9, 9, 9, 9, 9, 1, 1)};
    vecs[2] = '{x: 999,  y: 1000, e: mk_exp(9, 9, 9, 9, 9, 9, 0, 1)};
    vecs[3] = '{x: 0,    y: 1,    e: mk_exp(0, 0, 0, 0, 0, 1, 0, 0)};
    vecs[4] = '{x: 100,  y: 50,   e: mk_exp(1, 0, 0, 0, 5, 0, 0, 0)};
    vecs[5] = '{x: 2047, y: 998,  e: mk_exp(9, 9, 9, 9, 9, 8, 1, 0)};
    vecs[6] = '{x: 555,  y: 90,   e: mk_exp(5, 5, 5, 0, 9, 0, 0, 0)};

    // ---- reset ----
    clr         = 1'b0;
    bus.x_pos   = '0;
    bus.y_pos   = '0;
    bus.refresh = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_digits", int'({bus.x_hund, bus.x_tens, bus.x_ones,
                              bus.y_hund, bus.y_tens, bus.y_ones}), 0);
    sb.push_back(mk_exp(0, 0, 0, 0, 0, 0, 0, 0));
    clr = 1'b1;
    wait_valid("post_reset", 13);
    count_valids(100, nv);
    check("no_valid_after_reset", nv, 0);

    // ---- table-driven conversions ----
    foreach (vecs[i]) begin
      bus.x_pos = WIDTH'(vecs[i].x);
      bus.y_pos = WIDTH'(vecs[i].y);
      sb.push_back(vecs[i].e);
      wait_valid("vec", 13);
      @(negedge clk);
      check("valid_one_cycle", int'(bus.valid), 0);
      repeat (2) @(negedge clk);
    end

    // ---- change mid-conversion ----
    bus.x_pos = 11'd123;
    bus.y_pos = 11'd0;
    sb.push_back(mk_exp(1, 2, 3, 0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    check("busy_mid_conv", int'(bus.busy), 1);
    bus.x_pos = 11'd456;
    sb.push_back(mk_exp(4, 5, 6, 0, 0, 0, 0, 0));
    wait_valid("mid_first", 8);
    wait_valid("mid_second", 13);
    repeat (3) @(negedge clk);

    // ---- refresh in IDLE, unchanged inputs ----
    sb.push_back(mk_exp(4, 5, 6, 0, 0, 0, 0, 0));
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    wait_valid("refresh_idle", 12);
    count_valids(20, nv);
    check("refresh_single", nv, 0);

    // ---- refresh during SHIFT is dropped ----
    bus.y_pos = 11'd7;
    sb.push_back(mk_exp(4, 5, 6, 0, 0, 7, 0, 0));
    repeat (4) @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    wait_valid("refresh_shift", 8);
    count_valids(30, nv);
    check("refresh_dropped", nv, 0);

    // ---- reset mid-SHIFT ----
    bus.x_pos = 11'd777;
    repeat (6) @(negedge clk);
    clr = 1'b0;
    #1;
    check("abort_valid", int'(bus.valid), 0);
    check("abort_busy",  int'(bus.busy), 0);
    check("abort_digits", int'({bus.x_hund, bus.x_tens, bus.x_ones,
                                bus.y_hund, bus.y_tens, bus.y_ones}), 0);
    repeat (2) @(negedge clk);
    sb.push_back(mk_exp(7, 7, 7, 0, 0, 7, 0, 0));
    clr = 1'b1;
    wait_valid("post_abort", 13);
    count_valids(20, nv);
    check("no_valid_after_abort", nv, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
